// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART receiver.
// Sequences the receiver enable and turns the level-style byte-ready flag into
// single push events. Buffers bytes in a FIFO with a valid/ready output stream
// and raises an interrupt on threshold, idle timeout or overrun.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned LW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_en,
  input  logic          cfg_flush,
  input  logic [LW-1:0] cfg_thresh,
  input  logic          ovr_clr,
  output logic          rx_en,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    m_data,
  output logic [LW-1:0] level,
  output logic          overrun,
  output logic          timeout,
  output logic          irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_ARM = 2'd1,
    S_RUN = 2'd2
  } state_e;

  state_e          state_q;
  logic            rx_en_q;
  logic            rdy_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            m_valid_q;
  logic [7:0]      m_data_q, m_data_d;
  logic [CW-1:0]   idle_q, idle_d;
  logic            timeout_q, timeout_d;
  logic            overrun_q, overrun_d;
  logic            irq_q, irq_d;

  logic            new_byte;
  logic            pop;
  logic            full;
  logic            push_acc;
  logic            drop;

  // Enable sequencer: OFF -> ARM (one cycle to absorb stale rx_ready) -> RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      rx_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (cfg_en) begin
            state_q <= S_ARM;
            rx_en_q <= 1'b1;
          end else begin
            rx_en_q <= 1'b0;
          end
        end
        S_ARM: begin
          if (cfg_en) begin
            state_q <= S_RUN;
            rx_en_q <= 1'b1;
          end else begin
            state_q <= S_OFF;
            rx_en_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (!cfg_en) begin
            state_q <= S_OFF;
            rx_en_q <= 1'b0;
          end else begin
            rx_en_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_OFF;
          rx_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Delayed copy of rx_ready for rising-edge detection, tracked in every state
  always_ff @(posedge clk) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= rx_ready;
  end

  assign new_byte = rx_ready & ~rdy_q & (state_q == S_RUN);

  // FIFO pointer/level, head byte, idle timer and status next-state logic
  always_comb begin
    pop       = m_valid_q & m_ready;
    full      = (level_q == LW'(FIFO_DEPTH));
    push_acc  = new_byte & ~cfg_flush & (~full | pop);
    drop      = new_byte & ~cfg_flush & full & ~pop;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    m_data_d  = m_data_q;
    idle_d    = idle_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    irq_d     = 1'b0;

    if (cfg_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = PW'(wr_ptr_q + PW'(1));
      if (pop)      rd_ptr_d = PW'(rd_ptr_q + PW'(1));
      level_d = LW'(level_q + LW'(push_acc) - LW'(pop));
    end

    // Head after this edge: the incoming byte if it lands in the head slot
    if (push_acc && (wr_ptr_q == rd_ptr_d)) m_data_d = rx_data;
    else                                    m_data_d = mem_q[rd_ptr_d];

    if (push_acc || pop || cfg_flush || (level_q == '0)) idle_d = '0;
    else if (idle_q != CW'(TIMEOUT_CYCLES))              idle_d = CW'(idle_q + CW'(1));

    if (pop || cfg_flush)                    timeout_d = 1'b0;
    else if (idle_d == CW'(TIMEOUT_CYCLES))  timeout_d = 1'b1;

    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;

    irq_d = ((cfg_thresh != '0) && (level_d >= cfg_thresh)) | timeout_d | overrun_d;
  end

  // FIFO storage; reset keeps the head output deterministic
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push_acc) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // Registered FIFO state and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      m_valid_q <= (level_d != '0);
      m_data_q  <= m_data_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  assign rx_en   = rx_en_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign level   = level_q;
  assign overrun = overrun_q;
  assign timeout = timeout_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a vector table for enable sequencing and
// edge detection, plus sequences for full/overrun, threshold, timeout, flush
// and disable/re-enable.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TO    = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_en;
  logic          cfg_flush;
  logic [LW-1:0] cfg_thresh;
  logic          ovr_clr;
  logic          rx_en;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          m_valid;
  logic          m_ready;
  logic [7:0]    m_data;
  logic [LW-1:0] level;
  logic          overrun;
  logic          timeout;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_flush(cfg_flush),
    .cfg_thresh(cfg_thresh), .ovr_clr(ovr_clr), .rx_en(rx_en),
    .rx_ready(rx_ready), .rx_data(rx_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .level(level), .overrun(overrun),
    .timeout(timeout), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       rdy;
    logic [7:0] data;
    logic       mrdy;
    logic       e_rxen;
    logic       e_mv;
    logic       chk_d;
    logic [7:0] e_md;
    logic [4:0] e_lvl;
    logic       e_irq;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_ready = 1'b1;
    rx_data  = d;
    step();
    rx_ready = 1'b0;
    step();
  endtask

  initial begin
    // enable, single push from a long-held rx_ready, pop, stale-high re-arm
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 5'd1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 5'd1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 5'd1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 5'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 5'd1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};

    rst = 1'b1; cfg_en = 1'b0; cfg_flush = 1'b0; cfg_thresh = '0; ovr_clr = 1'b0;
    rx_ready = 1'b0; rx_data = 8'h00; m_ready = 1'b0;
    repeat (3) step();
    chk("reset rx_en", 32'(rx_en), 32'd0);
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset m_data", 32'(m_data), 32'd0);
    chk("reset level", 32'(level), 32'd0);
    chk("reset flags", {29'd0, overrun, timeout, irq}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cfg_en   = vecs[i].en;
      rx_ready = vecs[i].rdy;
      rx_data  = vecs[i].data;
      m_ready  = vecs[i].mrdy;
      step();
      chk($sformatf("vec%0d rx_en", i), 32'(rx_en), 32'(vecs[i].e_rxen));
      chk($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].e_lvl));
      chk($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].e_irq));
      if (vecs[i].chk_d) chk($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].e_md));
    end
    m_ready = 1'b0;

    // Overflow: 16 accepted, 17th dropped; overrun set wins over a coincident clear
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill level", 32'(level), 32'd16);
    chk("fill overrun", 32'(overrun), 32'd0);
    rx_ready = 1'b1; rx_data = 8'h10; ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0; rx_ready = 1'b0;
    chk("ovf level", 32'(level), 32'd16);
    chk("ovf overrun", 32'(overrun), 32'd1);
    chk("ovf irq", 32'(irq), 32'd1);
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d m_valid", i), 32'(m_valid), 32'd1);
      chk($sformatf("drain%0d m_data", i), 32'(m_data), 32'(i));
      step();
    end
    m_ready = 1'b0;
    chk("drained level", 32'(level), 32'd0);
    chk("drained m_valid", 32'(m_valid), 32'd0);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr overrun", 32'(overrun), 32'd0);
    chk("ovr_clr irq", 32'(irq), 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    rx_ready = 1'b1; rx_data = 8'h77; m_ready = 1'b1;
    step();
    rx_ready = 1'b0; m_ready = 1'b0;
    chk("fullpp level", 32'(level), 32'd16);
    chk("fullpp overrun", 32'(overrun), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpp drain%0d", i), 32'(m_data), (i == 15) ? 32'h77 : 32'(i + 1));
      step();
    end
    m_ready = 1'b0;
    chk("fullpp empty", 32'(level), 32'd0);

    // Threshold interrupt
    cfg_thresh = LW'(4);
    push_byte(8'hB1);
    chk("thr1 irq", 32'(irq), 32'd0);
    push_byte(8'hB2);
    push_byte(8'hB3);
    chk("thr3 irq", 32'(irq), 32'd0);
    push_byte(8'hB4);
    chk("thr4 irq", 32'(irq), 32'd1);
    cfg_thresh = '0;
    m_ready = 1'b1;
    repeat (4) step();
    m_ready = 1'b0;
    chk("thr drained", 32'(level), 32'd0);

    // Idle timeout: push edge then 8 idle cycles; a pop clears it
    push_byte(8'hC7);
    repeat (6) step();
    chk("to early", 32'(timeout), 32'd0);
    step();
    chk("to set", 32'(timeout), 32'd1);
    chk("to irq", 32'(irq), 32'd1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("to cleared", 32'(timeout), 32'd0);
    chk("to irq clr", 32'(irq), 32'd0);

    // Flush with a coincident push
    for (int i = 0; i < 5; i++) push_byte(8'hD0 + 8'(i));
    chk("preflush level", 32'(level), 32'd5);
    cfg_flush = 1'b1; rx_ready = 1'b1; rx_data = 8'h99;
    step();
    cfg_flush = 1'b0;
    chk("flush level", 32'(level), 32'd0);
    chk("flush m_valid", 32'(m_valid), 32'd0);
    chk("flush overrun", 32'(overrun), 32'd0);
    rx_ready = 1'b0;
    step();
    chk("flush no late push", 32'(level), 32'd0);

    // Disable, then rx_ready rises 3 cycles later: ignored
    cfg_en = 1'b0;
    step();
    chk("dis rx_en", 32'(rx_en), 32'd0);
    step();
    step();
    rx_ready = 1'b1; rx_data = 8'h42;
    step();
    step();
    chk("dis no push", 32'(level), 32'd0);

    // Re-enable with rx_ready still high: no double count
    cfg_en = 1'b1;
    step();
    step();
    step();
    chk("reen rx_en", 32'(rx_en), 32'd1);
    chk("reen no push", 32'(level), 32'd0);
    rx_ready = 1'b0;
    step();
    push_byte(8'h5A);
    chk("reen push level", 32'(level), 32'd1);
    chk("reen push data", 32'(m_data), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
